// File: rtl/mmio_pkg.sv
// mmio_pkg: register map shared by the GPIO bank and its ports.
package mmio_pkg;
    localparam int PORT_STRIDE = 8;
    localparam logic [2:0] OFS_OUT  = 3'd0;
    localparam logic [2:0] OFS_DIR  = 3'd1;
    localparam logic [2:0] OFS_IN   = 3'd2;
    localparam logic [2:0] OFS_IEN  = 3'd3;
    localparam logic [2:0] OFS_FLAG = 3'd4;
    localparam logic [2:0] OFS_EDGE = 3'd5;

    // Odd byte addresses ride on the upper data lane.
    function automatic logic [7:0] lane(input logic [15:0] w, input logic odd);
        return odd ? w[15:8] : w[7:0];
    endfunction
endpackage

// File: rtl/gpio_port.sv
// gpio_port: one 8-bit port with registers, input synchroniser, edge flags and readback.
module gpio_port
    import mmio_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  we,
    input  logic [15:0] wdata,
    input  logic [1:0]  rofs,
    input  logic [7:0]  pin,
    output logic [7:0]  out,
    output logic [7:0]  oe,
    output logic [15:0] rdata,
    output logic        irq_req
);
    logic [SYNC_STAGES-1:0][7:0] sync;
    logic [SYNC_STAGES:0] arm;
    logic [7:0] dly, out_r, dir_r, ien_r, flag_r, edge_r, last, hit, clr;
    logic [7:0] bank [8];

    assign last = sync[SYNC_STAGES-1];
    // Edges are ignored until the delay flop holds post-reset pin data.
    assign hit = arm[SYNC_STAGES] ? (last & ~dly & ~edge_r) | (~last & dly & edge_r) : 8'h00;
    assign clr = we[OFS_FLAG] ? lane(wdata, OFS_FLAG[0]) : 8'h00;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync   <= '0;
            dly    <= '0;
            arm    <= '0;
            out_r  <= '0;
            dir_r  <= '0;
            ien_r  <= '0;
            flag_r <= '0;
            edge_r <= '0;
        end else begin
            sync   <= {sync[SYNC_STAGES-2:0], pin};
            dly    <= last;
            arm    <= {arm[SYNC_STAGES-1:0], 1'b1};
            out_r  <= we[OFS_OUT]  ? lane(wdata, OFS_OUT[0])  : out_r;
            dir_r  <= we[OFS_DIR]  ? lane(wdata, OFS_DIR[0])  : dir_r;
            ien_r  <= we[OFS_IEN]  ? lane(wdata, OFS_IEN[0])  : ien_r;
            edge_r <= we[OFS_EDGE] ? lane(wdata, OFS_EDGE[0]) : edge_r;
            flag_r <= (flag_r & ~clr) | hit;
        end
    end

    always_comb begin
        for (int i = 0; i < 8; i++) bank[i] = 8'h00;
        bank[OFS_OUT]  = out_r;
        bank[OFS_DIR]  = dir_r;
        bank[OFS_IN]   = last;
        bank[OFS_IEN]  = ien_r;
        bank[OFS_FLAG] = flag_r;
        bank[OFS_EDGE] = edge_r;
    end

    assign rdata   = {bank[{rofs, 1'b1}], bank[{rofs, 1'b0}]};
    assign out     = out_r;
    assign oe      = dir_r;
    assign irq_req = |(flag_r & ien_r);
endmodule

// File: rtl/mmio_gpio_bank.sv
// mmio_gpio_bank: memory-mapped bank of NPORT GPIO ports with edge-triggered interrupts.
module mmio_gpio_bank
    import mmio_pkg::*;
#(
    parameter int NPORT       = 4,
    parameter int ADDR_WIDTH  = 10,
    parameter int BASE_ADDR   = 'h080,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] dmem_addr,
    input  logic                  dmem_wen,
    input  logic                  dmem_byt,
    input  logic [15:0]           dmem_wdata,
    output logic [15:0]           dmem_rdata,
    input  logic [8*NPORT-1:0]    gpio_in,
    output logic [8*NPORT-1:0]    gpio_out,
    output logic [8*NPORT-1:0]    gpio_oe,
    output logic                  irq
);
    localparam logic [ADDR_WIDTH-1:0] BASE = ADDR_WIDTH'(BASE_ADDR);
    localparam logic [ADDR_WIDTH-1:0] SPAN = ADDR_WIDTH'(PORT_STRIDE * NPORT);

    logic [ADDR_WIDTH-1:0] rel;
    logic                  in_blk;
    logic [3:0]            pidx;
    logic [2:0]            ofs;
    logic [7:0]            wmask;
    logic [15:0]           rd_nxt;
    logic [15:0]           port_rd [NPORT];
    logic [NPORT-1:0]      port_irq;

    assign rel    = dmem_addr - BASE;
    assign in_blk = dmem_addr >= BASE && rel < SPAN;
    assign pidx   = rel[6:3];
    assign ofs    = rel[2:0];
    // Word writes cover the addressed byte and its odd neighbour; odd word writes are dropped.
    assign wmask  = !(dmem_wen && in_blk) ? 8'h00 : dmem_byt ? 8'b01 << ofs : ofs[0] ? 8'h00 : 8'b11 << ofs;

    for (genvar g = 0; g < NPORT; g++) begin : g_port
        gpio_port #(.SYNC_STAGES(SYNC_STAGES)) u_port (
            .clk    (clk),
            .rst    (rst),
            .we     (pidx == 4'(g) ? wmask : 8'h00),
            .wdata  (dmem_wdata),
            .rofs   (ofs[2:1]),
            .pin    (gpio_in[8*g +: 8]),
            .out    (gpio_out[8*g +: 8]),
            .oe     (gpio_oe[8*g +: 8]),
            .rdata  (port_rd[g]),
            .irq_req(port_irq[g])
        );
    end

    always_comb begin
        rd_nxt = 16'h0000;
        for (int i = 0; i < NPORT; i++) rd_nxt = (in_blk && pidx == 4'(i)) ? port_rd[i] : rd_nxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dmem_rdata <= '0;
            irq        <= 1'b0;
        end else begin
            dmem_rdata <= rd_nxt;
            irq        <= |port_irq;
        end
    end
endmodule

// File: tb/tb_mmio_gpio_bank.sv
// tb_mmio_gpio_bank: directed vector table plus hand sequences for edges, W1C and reset.
module tb_mmio_gpio_bank;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [9:0]  dmem_addr = '0;
    logic        dmem_wen = 1'b0;
    logic        dmem_byt = 1'b0;
    logic [15:0] dmem_wdata = '0;
    logic [15:0] dmem_rdata;
    logic [31:0] gpio_in = '0;
    logic [31:0] gpio_out, gpio_oe;
    logic        irq;
    int          pass = 0;
    int          total = 0;

    typedef struct {
        logic        wen, byt;
        logic [9:0]  waddr;
        logic [15:0] wdata;
        logic [9:0]  raddr;
        logic [31:0] out, oe;
        logic [15:0] rd;
    } vec_t;
    vec_t vecs [12];

    mmio_gpio_bank dut (
        .clk(clk), .rst(rst), .dmem_addr(dmem_addr), .dmem_wen(dmem_wen), .dmem_byt(dmem_byt),
        .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .gpio_in(gpio_in),
        .gpio_out(gpio_out), .gpio_oe(gpio_oe), .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic wr(input logic byt, input logic [9:0] addr, input logic [15:0] data);
        dmem_wen = 1'b1; dmem_byt = byt; dmem_addr = addr; dmem_wdata = data;
        tick();
        dmem_wen = 1'b0;
    endtask

    initial begin
        vecs[0]  = '{1'b1, 1'b0, 10'h080, 16'h0F0A, 10'h080, 32'h0000000A, 32'h0000000F, 16'h0F0A};
        vecs[1]  = '{1'b1, 1'b1, 10'h081, 16'hAB00, 10'h080, 32'h0000000A, 32'h000000AB, 16'hAB0A};
        vecs[2]  = '{1'b1, 1'b0, 10'h081, 16'h5555, 10'h080, 32'h0000000A, 32'h000000AB, 16'hAB0A};
        vecs[3]  = '{1'b1, 1'b1, 10'h080, 16'h0033, 10'h080, 32'h00000033, 32'h000000AB, 16'hAB33};
        vecs[4]  = '{1'b1, 1'b0, 10'h0A0, 16'h1234, 10'h0A0, 32'h00000033, 32'h000000AB, 16'h0000};
        vecs[5]  = '{1'b1, 1'b1, 10'h098, 16'h00C5, 10'h098, 32'hC5000033, 32'h000000AB, 16'h00C5};
        vecs[6]  = '{1'b1, 1'b0, 10'h098, 16'h7E5A, 10'h098, 32'h5A000033, 32'h7E0000AB, 16'h7E5A};
        vecs[7]  = '{1'b1, 1'b1, 10'h08B, 16'h3C00, 10'h08A, 32'h5A000033, 32'h7E0000AB, 16'h3C00};
        vecs[8]  = '{1'b1, 1'b0, 10'h08C, 16'h0201, 10'h08C, 32'h5A000033, 32'h7E0000AB, 16'h0200};
        vecs[9]  = '{1'b1, 1'b0, 10'h08E, 16'hFFFF, 10'h08E, 32'h5A000033, 32'h7E0000AB, 16'h0000};
        vecs[10] = '{1'b1, 1'b1, 10'h07F, 16'hFFFF, 10'h07E, 32'h5A000033, 32'h7E0000AB, 16'h0000};
        vecs[11] = '{1'b1, 1'b1, 10'h089, 16'h6600, 10'h088, 32'h5A000033, 32'h7E0066AB, 16'h6600};

        tick();
        tick();
        chk("reset out", gpio_out, 32'h0);
        chk("reset oe", gpio_oe, 32'h0);
        chk("reset rdata", 32'(dmem_rdata), 32'h0);
        chk("reset irq", 32'(irq), 32'h0);
        rst = 1'b0;
        tick();

        foreach (vecs[i]) begin
            dmem_wen = vecs[i].wen; dmem_byt = vecs[i].byt;
            dmem_addr = vecs[i].waddr; dmem_wdata = vecs[i].wdata;
            tick();
            dmem_wen = 1'b0; dmem_addr = vecs[i].raddr;
            tick();
            chk($sformatf("vec%0d out", i), gpio_out, vecs[i].out);
            chk($sformatf("vec%0d oe", i), gpio_oe, vecs[i].oe);
            chk($sformatf("vec%0d rdata", i), 32'(dmem_rdata), 32'(vecs[i].rd));
            chk($sformatf("vec%0d irq", i), 32'(irq), 32'h0);
        end

        // Rising edge on pin 0 with IEN0 bit 0 set: flag after 3 edges, irq one later.
        wr(1'b1, 10'h083, 16'h0100);
        dmem_addr = 10'h084;
        gpio_in[0] = 1'b1;
        tick();
        tick();
        tick();
        chk("rise early irq", 32'(irq), 32'h0);
        chk("rise early flag", 32'(dmem_rdata), 32'h0000);
        tick();
        chk("rise irq", 32'(irq), 32'h1);
        chk("rise flag", 32'(dmem_rdata), 32'h0001);
        wr(1'b1, 10'h084, 16'h0001);
        tick();
        chk("w1c irq", 32'(irq), 32'h0);
        chk("w1c flag", 32'(dmem_rdata), 32'h0000);

        // Falling edge with rising polarity must not flag.
        gpio_in[0] = 1'b0;
        repeat (5) tick();
        chk("fall ignored flag", 32'(dmem_rdata), 32'h0000);
        chk("fall ignored irq", 32'(irq), 32'h0);

        // W1C landing on the same edge that sets the flag: set wins.
        gpio_in[0] = 1'b1;
        tick();
        tick();
        wr(1'b1, 10'h084, 16'h0001);
        dmem_addr = 10'h084;
        tick();
        tick();
        chk("set wins flag", 32'(dmem_rdata), 32'h0001);
        chk("set wins irq", 32'(irq), 32'h1);
        wr(1'b1, 10'h084, 16'h0001);
        tick();
        tick();
        chk("clear again", 32'(dmem_rdata), 32'h0000);

        // Falling polarity selected: falling edge flags.
        wr(1'b1, 10'h085, 16'h0100);
        dmem_addr = 10'h084;
        gpio_in[0] = 1'b0;
        repeat (5) tick();
        chk("fall flag", 32'(dmem_rdata), 32'h0101);
        chk("fall irq", 32'(irq), 32'h1);

        // Reset during a word write with all pins high.
        gpio_in = '1;
        dmem_wen = 1'b1; dmem_byt = 1'b0; dmem_addr = 10'h080; dmem_wdata = 16'hFFFF;
        #2 rst = 1'b1;
        tick();
        chk("rst out", gpio_out, 32'h0);
        chk("rst oe", gpio_oe, 32'h0);
        chk("rst rdata", 32'(dmem_rdata), 32'h0);
        chk("rst irq", 32'(irq), 32'h0);
        rst = 1'b0;
        dmem_wen = 1'b0;
        wr(1'b1, 10'h083, 16'hFF00);
        dmem_addr = 10'h084;
        repeat (6) tick();
        chk("post rst flag", 32'(dmem_rdata), 32'h0000);
        chk("post rst irq", 32'(irq), 32'h0);
        chk("post rst out", gpio_out, 32'h0);
        dmem_addr = 10'h082;
        tick();
        chk("post rst in", 32'(dmem_rdata), 32'hFFFF);

        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end
endmodule

// File: doc/mmio_gpio_bank.md
MMIO_GPIO_BANK -- requirements
Module: mmio_gpio_bank

Interface
REQ-001 Parameter NPORT, default 4: number of 8-bit ports, range 1..16.
REQ-002 Parameter ADDR_WIDTH, default 10: data-bus byte-address width.
REQ-003 Parameter BASE_ADDR, default 'h080: byte address of port 0; SHALL be a multiple of 8*NPORT rounded up to a power of two.
REQ-004 Parameter SYNC_STAGES, default 2: input synchroniser depth, range 2..3.
REQ-005 clk  in  1  single clock for all logic.
REQ-006 rst  in  1  asynchronous active-high reset.
REQ-007 dmem_addr  in  ADDR_WIDTH  byte address from the CPU.
REQ-008 dmem_wen  in  1  write strobe, one cycle per write.
REQ-009 dmem_byt  in  1  1 = byte access, 0 = 16-bit word access.
REQ-010 dmem_wdata  in  16  write data.
REQ-011 dmem_rdata  out  16  registered read data for the previous cycle's address.
REQ-012 gpio_in  in  8*NPORT  raw pin inputs, asynchronous to clk.
REQ-013 gpio_out  out  8*NPORT  output drive values.
REQ-014 gpio_oe  out  8*NPORT  output enables, 1 = drive.
REQ-015 irq  out  1  level interrupt request to the CPU.

Function
REQ-016 Port p SHALL occupy bytes BASE_ADDR+8p .. +8p+7: +0 OUT (RW), +1 DIR (RW), +2 IN (RO), +3 IEN (RW), +4 FLAG (W1C), +5 EDGE (RW; bit 0 = rising, 1 = falling), +6 and +7 reserved (read 0, writes ignored).
REQ-017 A byte write SHALL take wdata[7:0] when addr[0]=0 and wdata[15:8] when addr[0]=1.
REQ-018 A word write at an even address SHALL write wdata[7:0] to addr and wdata[15:8] to addr+1 in the same cycle.
REQ-019 A word write at an odd address SHALL be ignored.
REQ-020 Writes outside BASE_ADDR .. BASE_ADDR+8*NPORT-1 SHALL be ignored.
REQ-021 Register updates SHALL be visible on gpio_out/gpio_oe on the clock edge after the write cycle.
REQ-022 dmem_rdata SHALL be registered: the cycle after address A is presented, it SHALL equal {byte(A|1), byte(A&~1)}.
REQ-023 dmem_rdata SHALL be 0 for addresses outside the block.
REQ-024 gpio_in SHALL pass through SYNC_STAGES flip-flops; IN SHALL read the synchronised value.
REQ-025 An edge SHALL be detected by comparing the last synchroniser stage with one further delay flop, giving a detection latency of SYNC_STAGES+1 cycles from the pin change.
REQ-026 A detected edge matching the bit's EDGE polarity SHALL set that FLAG bit.
REQ-027 A FLAG write SHALL clear only the bits written as 1.
REQ-028 If an edge set and a W1C clear hit the same bit in the same cycle, the set SHALL win.
REQ-029 Edges SHALL be detected for every bit regardless of DIR; IEN gates only irq.
REQ-030 irq SHALL be registered as the OR over all ports of (FLAG & IEN); it SHALL assert one cycle after a FLAG bit sets with IEN=1.
REQ-031 Writing IEN SHALL NOT alter FLAG.

Reset
REQ-032 While rst=1, OUT, DIR, IEN, FLAG, EDGE, the synchroniser and delay flops, dmem_rdata and irq SHALL all be 0.
REQ-033 A reset asserted mid-transfer SHALL discard that write.
REQ-034 After reset deassertion, no FLAG bit SHALL set until the edge-delay flop has captured post-reset input data, i.e. no spurious edges.

Structure
REQ-035 Register offsets (OFS_OUT .. OFS_EDGE) and PORT_STRIDE=8 SHALL live in the shared package mmio_pkg.
REQ-036 A single sub-module, gpio_port (one 8-bit port holding its registers, synchroniser, edge logic and byte readback), SHALL be instantiated NPORT times with a generate loop.

Verification
REQ-037 Reset, then word write 'h0F0A to 'h080 -> next cycle gpio_out[7:0]='h0A, gpio_oe[7:0]='h0F; read 'h080 returns 'h0F0A one cycle later.
REQ-038 Byte write wdata='hAB00 to 'h081 -> DIR0='hAB and OUT0 unchanged; word write to 'h081 -> no register changes.
REQ-039 IEN0='h01, EDGE0=0, gpio_in[0] rises -> FLAG0 bit 0 sets SYNC_STAGES+1 cycles later and irq is high one cycle after that; byte write 'h01 to 'h084 -> FLAG clears and irq drops.
REQ-040 Edge on bit 0 in the same cycle as a W1C of bit 0 -> FLAG0[0] stays 1.
REQ-041 NPORT=4: write and read 'h0A0 (outside the block) -> no register changes, read returns 0; port 3 OUT at 'h098 reads back.
REQ-042 Assert rst during a word write with gpio_in held high -> all outputs 0, and after release FLAG stays 0.
